// File: rtl/cam_pkg.sv
// Shared definitions for the camera view scheduler.
// Contents: view index width and view count, the scheduler state encoding,
// and shortest_dir(), which picks the wrap-around direction toward a target view.
package cam_pkg;

  localparam int OFFSET_W  = 6;
  localparam int NUM_VIEWS = 2 ** OFFSET_W;

  localparam logic [OFFSET_W-1:0] OFF_HALF  = OFFSET_W'(NUM_VIEWS / 2);
  localparam logic [OFFSET_W-1:0] OFF_PLUS  = {{(OFFSET_W-1){1'b0}}, 1'b1};
  localparam logic [OFFSET_W-1:0] OFF_MINUS = {OFFSET_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MANUAL = 2'd1,
    ST_GOTO   = 2'd2,
    ST_AUTO   = 2'd3
  } cam_state_e;

  // Returns +1 or -1: the direction of the shortest path around the ring.
  // When the target is exactly half the ring away, +1 is chosen.
  function automatic logic signed [1:0] shortest_dir(
    input logic [OFFSET_W-1:0] cur,
    input logic [OFFSET_W-1:0] tgt
  );
    logic [OFFSET_W-1:0] diff;
    diff = tgt - cur;
    if (diff > OFF_HALF) begin
      return 2'sb11;
    end else begin
      return 2'sb01;
    end
  endfunction

endpackage

// File: rtl/cam_edge_detect.sv
// Registered rising-edge detector for one debounced button level.
// Ports: clk, rst_n (async active-low), i_level (button level),
//        o_rise (1-cycle pulse, one cycle after the level is first seen high).
// The history register resets to 1, so a level already high when reset
// is released does not count as a press.
module cam_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_level,
  output logic o_rise
);

  logic r_prev;
  logic r_rise;

  // Level history and registered edge pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev <= 1'b1;
      r_rise <= 1'b0;
    end else begin
      r_prev <= i_level;
      r_rise <= i_level & ~r_prev;
    end
  end

  assign o_rise = r_rise;

endmodule

// File: rtl/camera_view_scheduler.sv
// Camera view scheduler: arbitrates the virtual-camera view index between
// manual buttons, an auto-rotate timer and a host goto handshake. The view
// changes only on a vsync cycle, by at most one step per frame.
// Ports: clk, rst_n (async active-low), i_vsync (frame-start pulse),
//        i_left / i_right (button levels), i_auto_en (auto-rotate enable),
//        i_goto_valid / i_goto_offset / o_goto_ready (host target handshake),
//        o_camera_offset (current view), o_offset_update (view-changed pulse),
//        o_busy (manual backlog or goto in progress).
module camera_view_scheduler
  import cam_pkg::*;
#(
  parameter int AUTO_PERIOD = 30,
  parameter int PEND_MAX    = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_vsync,
  input  logic                i_left,
  input  logic                i_right,
  input  logic                i_auto_en,
  input  logic                i_goto_valid,
  input  logic [OFFSET_W-1:0] i_goto_offset,
  output logic                o_goto_ready,
  output logic [OFFSET_W-1:0] o_camera_offset,
  output logic                o_offset_update,
  output logic                o_busy
);

  localparam int PEND_W = $clog2(PEND_MAX + 1) + 1;
  localparam int PW     = PEND_W + 2;
  localparam int FCNT_W = $clog2(AUTO_PERIOD + 1) + 1;

  localparam logic signed [PW-1:0] P_MAX  = PW'(PEND_MAX);
  localparam logic signed [PW-1:0] P_MIN  = -P_MAX;
  localparam logic signed [PW-1:0] P_ONE  = {{(PW-1){1'b0}}, 1'b1};
  localparam logic signed [PW-1:0] P_NEG1 = {PW{1'b1}};
  localparam logic signed [PW-1:0] P_NONE = {PW{1'b0}};
  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(AUTO_PERIOD - 1);
  localparam logic [FCNT_W-1:0] FCNT_ONE  = {{(FCNT_W-1){1'b0}}, 1'b1};

  cam_state_e                 r_state;
  logic [OFFSET_W-1:0]        r_offset;
  logic [OFFSET_W-1:0]        r_target;
  logic                       r_update;
  logic signed [PEND_W-1:0]   r_pend;
  logic [FCNT_W-1:0]          r_frame_cnt;

  logic                       w_rise_l;
  logic                       w_rise_r;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_pend_nz;
  logic signed [PW-1:0]       w_p_ext;
  logic signed [PW-1:0]       w_delta;
  logic signed [PW-1:0]       w_toward;
  logic signed [PEND_W-1:0]   w_pend_edge;
  logic signed [PEND_W-1:0]   w_pend_vs;
  logic signed [1:0]          w_dir;
  logic [OFFSET_W-1:0]        w_goto_step;
  logic [OFFSET_W-1:0]        w_man_step;

  function automatic logic signed [PEND_W-1:0] sat_pend(input logic signed [PW-1:0] v);
    if (v > P_MAX) begin
      return P_MAX[PEND_W-1:0];
    end else if (v < P_MIN) begin
      return P_MIN[PEND_W-1:0];
    end else begin
      return v[PEND_W-1:0];
    end
  endfunction

  cam_edge_detect u_edge_left  (.clk(clk), .rst_n(rst_n), .i_level(i_left),  .o_rise(w_rise_l));
  cam_edge_detect u_edge_right (.clk(clk), .rst_n(rst_n), .i_level(i_right), .o_rise(w_rise_r));

  assign w_ready   = (r_state != ST_GOTO);
  assign w_accept  = i_goto_valid & w_ready;
  assign w_pend_nz = (r_pend != {PEND_W{1'b0}});

  // Backlog arithmetic: new edges, plus the one-toward-zero move on a manual step.
  always_comb begin
    w_p_ext = {{2{r_pend[PEND_W-1]}}, r_pend};
    case ({w_rise_r, w_rise_l})
      2'b10:   w_delta = P_ONE;
      2'b01:   w_delta = P_NEG1;
      default: w_delta = P_NONE;
    endcase
    if (w_p_ext > P_NONE) begin
      w_toward = P_NEG1;
    end else if (w_p_ext < P_NONE) begin
      w_toward = P_ONE;
    end else begin
      w_toward = P_NONE;
    end
    w_pend_edge = sat_pend(w_p_ext + w_delta);
    w_pend_vs   = sat_pend(w_p_ext + w_toward + w_delta);
  end

  // Step values for the goto path and the manual backlog sign.
  always_comb begin
    w_dir       = shortest_dir(r_offset, r_target);
    w_goto_step = {{(OFFSET_W-1){w_dir[1]}}, 1'b1};
    if (r_pend[PEND_W-1]) begin
      w_man_step = OFF_MINUS;
    end else begin
      w_man_step = OFF_PLUS;
    end
  end

  // Scheduler FSM with backlog, frame counter and offset register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_offset    <= {OFFSET_W{1'b0}};
      r_target    <= {OFFSET_W{1'b0}};
      r_update    <= 1'b0;
      r_pend      <= {PEND_W{1'b0}};
      r_frame_cnt <= {FCNT_W{1'b0}};
    end else begin
      r_update    <= 1'b0;
      r_pend      <= w_pend_edge;
      r_frame_cnt <= {FCNT_W{1'b0}};
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_target <= i_goto_offset;
            r_pend   <= {PEND_W{1'b0}};
            r_state  <= ST_GOTO;
          end else if (w_pend_nz) begin
            r_state <= ST_MANUAL;
          end else if (i_auto_en) begin
            r_state <= ST_AUTO;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_MANUAL: begin
          if (w_accept) begin
            r_target <= i_goto_offset;
            r_pend   <= {PEND_W{1'b0}};
            r_state  <= ST_GOTO;
          end else if (!w_pend_nz) begin
            r_state <= i_auto_en ? ST_AUTO : ST_IDLE;
          end else if (i_vsync) begin
            r_offset <= r_offset + w_man_step;
            r_update <= 1'b1;
            r_pend   <= w_pend_vs;
          end else begin
            r_state <= ST_MANUAL;
          end
        end
        ST_GOTO: begin
          // Button edges arriving while a goto is in flight are discarded.
          r_pend <= {PEND_W{1'b0}};
          if (r_offset == r_target) begin
            r_state <= i_auto_en ? ST_AUTO : ST_IDLE;
          end else if (i_vsync) begin
            r_offset <= r_offset + w_goto_step;
            r_update <= 1'b1;
          end else begin
            r_state <= ST_GOTO;
          end
        end
        ST_AUTO: begin
          if (w_accept) begin
            r_target <= i_goto_offset;
            r_pend   <= {PEND_W{1'b0}};
            r_state  <= ST_GOTO;
          end else if (w_pend_nz) begin
            r_state <= ST_MANUAL;
          end else if (!i_auto_en) begin
            r_state <= ST_IDLE;
          end else if (i_vsync) begin
            if (r_frame_cnt == FCNT_LAST) begin
              r_offset <= r_offset + OFF_PLUS;
              r_update <= 1'b1;
            end else begin
              r_frame_cnt <= r_frame_cnt + FCNT_ONE;
            end
          end else begin
            r_frame_cnt <= r_frame_cnt;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_goto_ready    = w_ready;
  assign o_camera_offset = r_offset;
  assign o_offset_update = r_update;
  assign o_busy          = (r_state == ST_MANUAL) || (r_state == ST_GOTO);

endmodule

// File: tb/tb_camera_view_scheduler.sv
module tb_camera_view_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_vsync = 1'b0;
  logic       i_left = 1'b0;
  logic       i_right = 1'b0;
  logic       i_auto_en = 1'b0;
  logic       i_goto_valid = 1'b0;
  logic [5:0] i_goto_offset = 6'd0;
  logic       o_goto_ready;
  logic [5:0] o_camera_offset;
  logic       o_offset_update;
  logic       o_busy;

  int n_checks = 0;
  int n_errors = 0;

  camera_view_scheduler #(.AUTO_PERIOD(3), .PEND_MAX(7)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_vsync         (i_vsync),
    .i_left          (i_left),
    .i_right         (i_right),
    .i_auto_en       (i_auto_en),
    .i_goto_valid    (i_goto_valid),
    .i_goto_offset   (i_goto_offset),
    .o_goto_ready    (o_goto_ready),
    .o_camera_offset (o_camera_offset),
    .o_offset_update (o_offset_update),
    .o_busy          (o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_vsync = 1'b0; i_left = 1'b0; i_right = 1'b0;
    i_auto_en = 1'b0; i_goto_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic vsync();
    i_vsync = 1'b1;
    tick();
    i_vsync = 1'b0;
  endtask

  task automatic press_right();
    i_right = 1'b1; tick(); i_right = 1'b0; tick();
  endtask

  task automatic press_left();
    i_left = 1'b1; tick(); i_left = 1'b0; tick();
  endtask

  task automatic goto(input logic [5:0] tgt, input logic with_vsync);
    i_goto_valid = 1'b1; i_goto_offset = tgt; i_vsync = with_vsync;
    tick();
    i_goto_valid = 1'b0; i_vsync = 1'b0;
  endtask

  initial begin
    logic [5:0] exp3 [6];
    exp3[0] = 6'd1;  exp3[1] = 6'd0;  exp3[2] = 6'd63;
    exp3[3] = 6'd62; exp3[4] = 6'd61; exp3[5] = 6'd60;

    // Test 1: reset values, three right presses, four vsyncs
    do_reset();
    chk("rst_offset", 32'(o_camera_offset), 32'd0);
    chk("rst_update", 32'(o_offset_update), 32'd0);
    chk("rst_ready",  32'(o_goto_ready),    32'd1);
    chk("rst_busy",   32'(o_busy),          32'd0);
    press_right(); press_right(); press_right();
    tick();
    chk("t1_busy_manual", 32'(o_busy), 32'd1);
    for (int k = 1; k <= 3; k++) begin
      vsync();
      chk("t1_offset", 32'(o_camera_offset), 32'(k));
      chk("t1_update", 32'(o_offset_update), 32'd1);
      tick();
      chk("t1_update_off", 32'(o_offset_update), 32'd0);
    end
    chk("t1_busy_done", 32'(o_busy), 32'd0);
    vsync();
    chk("t1_vs4_offset", 32'(o_camera_offset), 32'd3);
    chk("t1_vs4_update", 32'(o_offset_update), 32'd0);

    // Test 2: wrap below zero, cancelling simultaneous edges
    do_reset();
    press_left(); tick();
    vsync();
    chk("t2_wrap", 32'(o_camera_offset), 32'd63);
    tick(); tick();
    i_left = 1'b1; i_right = 1'b1; tick();
    i_left = 1'b0; i_right = 1'b0; tick(); tick(); tick();
    chk("t2_cancel_busy", 32'(o_busy), 32'd0);
    vsync();
    chk("t2_cancel_offset", 32'(o_camera_offset), 32'd63);

    // Test 3: goto 60 from 2 going backwards through the wrap
    do_reset();
    press_right(); press_right(); tick();
    vsync(); tick(); vsync(); tick(); tick();
    chk("t3_start", 32'(o_camera_offset), 32'd2);
    chk("t3_ready_pre", 32'(o_goto_ready), 32'd1);
    goto(6'd60, 1'b0);
    chk("t3_ready_goto", 32'(o_goto_ready), 32'd0);
    for (int k = 0; k < 6; k++) begin
      if (k == 2 || k == 4) press_left();
      vsync();
      chk("t3_step", 32'(o_camera_offset), 32'(exp3[k]));
      chk("t3_ready", 32'(o_goto_ready), 32'd0);
      tick();
    end
    tick();
    chk("t3_ready_after", 32'(o_goto_ready), 32'd1);
    vsync(); tick();
    chk("t3_no_left", 32'(o_camera_offset), 32'd60);
    chk("t3_busy_after", 32'(o_busy), 32'd0);

    // Test 4: tie distance goes +1; vsync on accept cycle does not step
    do_reset();
    goto(6'd32, 1'b1);
    chk("t4_accept_offset", 32'(o_camera_offset), 32'd0);
    chk("t4_accept_update", 32'(o_offset_update), 32'd0);
    vsync();
    chk("t4_first_step", 32'(o_camera_offset), 32'd1);
    for (int k = 0; k < 31; k++) begin
      tick(); vsync();
    end
    chk("t4_final", 32'(o_camera_offset), 32'd32);
    tick(); tick();
    chk("t4_idle_ready", 32'(o_goto_ready), 32'd1);

    // Test 5: auto-rotate period 3, manual press mid-period
    do_reset();
    i_auto_en = 1'b1;
    tick();
    for (int k = 1; k <= 9; k++) begin
      vsync();
      if (k % 3 == 0) begin
        chk("t5_auto_offset", 32'(o_camera_offset), 32'(k / 3));
        chk("t5_auto_update", 32'(o_offset_update), 32'd1);
      end
      tick();
    end
    vsync(); tick();
    chk("t5_mid_period", 32'(o_camera_offset), 32'd3);
    press_right(); tick();
    chk("t5_manual_busy", 32'(o_busy), 32'd1);
    vsync();
    chk("t5_manual_step", 32'(o_camera_offset), 32'd4);
    tick(); tick();
    chk("t5_back_auto", 32'(o_busy), 32'd0);
    vsync(); tick(); vsync(); tick();
    chk("t5_cnt_cleared", 32'(o_camera_offset), 32'd4);
    vsync();
    chk("t5_auto_resume", 32'(o_camera_offset), 32'd5);
    i_auto_en = 1'b0;
    tick();

    // Test 6: asynchronous reset in the middle of a goto
    do_reset();
    goto(6'd10, 1'b0);
    vsync(); tick(); vsync(); tick();
    chk("t6_pre_reset", 32'(o_camera_offset), 32'd2);
    i_right = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_offset", 32'(o_camera_offset), 32'd0);
    chk("t6_async_ready",  32'(o_goto_ready),    32'd1);
    tick();
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t6_no_press_busy", 32'(o_busy), 32'd0);
    vsync();
    chk("t6_no_update", 32'(o_offset_update), 32'd0);
    chk("t6_offset_hold", 32'(o_camera_offset), 32'd0);
    i_right = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
